// File: rtl/mult8_seq_pkg.sv
// Shared constants for the sequential shift-and-add multiplier: state
// encodings and the default operand width.
package mult8_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mult8_seq_ripple.sv
// WIDTH-bit ripple-carry adder used for the partial-product accumulation
// step of the multiplier.
module mult8_seq_ripple #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/mult8_seq.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// registered 2*WIDTH-bit product held stable between done pulses.
module mult8_seq
    import mult8_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mq_next;

    assign addend = mq[0] ? mcand : '0;

    mult8_seq_ripple #(.WIDTH(WIDTH)) u_ripple (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // The carry becomes the new acc MSB; the sum LSB shifts into mq.
    always_comb begin
        acc_next = {carry, sum[WIDTH-1:1]};
        mq_next  = {sum[0], mq[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        count <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    mq    <= mq_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        product <= {acc_next, mq_next};
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
